// File: rtl/rr_sel_arbiter4.sv
// rr_sel_arbiter4
//
// Four-channel round-robin arbiter that drives the selection_line of a
// downstream 4:1 selector (mux4to1) together with a matching one-hot grant.
// A grant lasts until one of three things happens: the owner raises
// release_i, the owner drops its request, or the owner has held the grant
// for MAX_HOLD consecutive cycles. When a grant ends, the priority pointer
// moves to the channel after the old owner. Arbitration runs again on that
// same edge, so no idle cycle is inserted between owners.
//
// Parameters:
//   MAX_HOLD  max consecutive cycles one owner may hold a grant (0 = no limit)
//   HOLD_W    hold counter width; 2**HOLD_W must exceed MAX_HOLD
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           synchronous active-low reset
//   req[3:0]        level-sensitive request per channel
//   release_i       current owner finished (ignored while idle)
//   selection_line  binary index of the current owner; holds while idle
//   grant[3:0]      one-hot grant, zero when there is no owner
//   grant_valid     high while a grant is active
//   timeout         one-cycle pulse after a forced release
//
// All outputs are registered. No combinational path runs from the inputs
// to the outputs.

module rr_sel_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       release_i,
  output logic [1:0] selection_line,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        grant_q, grant_d;
  logic              valid_q, valid_d;
  logic              to_q, to_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [1:0]        ptr_next;
  logic [2:0]        pick;
  logic              owner_req;
  logic              hold_limit;
  logic              do_release;

  // Returns {found, index}. Channels are scanned starting at p, wrapping
  // modulo 4. The first requester found wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!res[2] && r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign owner_req  = req[sel_q];
  assign hold_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign do_release = release_i || !owner_req || hold_limit;

  // While idle the search starts at the stored pointer. When a grant ends it
  // starts just past the old owner, which therefore has lowest priority.
  assign ptr_next = (state_q == S_GRANT) ? sel_q + 2'd1 : ptr_q;
  assign pick     = rr_pick(req, ptr_next);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    to_d    = 1'b0;
    hold_d  = hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick[2]) begin
          state_d = S_GRANT;
          sel_d   = pick[1:0];
          grant_d = 4'b0001 << pick[1:0];
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end

      S_GRANT: begin
        if (!do_release) begin
          // Saturate the counter. This matters only when MAX_HOLD is 0,
          // because then no limit ever resets the count.
          if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          ptr_d = ptr_next;
          // Report a timeout only when the hold limit alone ends the grant.
          to_d  = hold_limit && !release_i && owner_req;
          if (pick[2]) begin
            sel_d   = pick[1:0];
            grant_d = 4'b0001 << pick[1:0];
            valid_d = 1'b1;
            hold_d  = '0;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
    end
  end

  assign selection_line = sel_q;
  assign grant          = grant_q;
  assign grant_valid    = valid_q;
  assign timeout        = to_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Testbench for rr_sel_arbiter4. Each applied vector pushes its expected
// outputs into a scoreboard queue. After the clock edge, the entry is popped
// and compared with the DUT outputs. A second instance with MAX_HOLD=0 runs
// in parallel and checks that the hold limit can be disabled.

module tb_rr_sel_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       release_i;

  logic [1:0] selection_line;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;

  logic [1:0] nh_sel;
  logic [3:0] nh_grant;
  logic       nh_valid;
  logic       nh_timeout;

  always #5 clk = ~clk;

  rr_sel_arbiter4 #(.MAX_HOLD(16), .HOLD_W(5)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .release_i      (release_i),
    .selection_line (selection_line),
    .grant          (grant),
    .grant_valid    (grant_valid),
    .timeout        (timeout)
  );

  rr_sel_arbiter4 #(.MAX_HOLD(0), .HOLD_W(5)) u_nohold (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .release_i      (release_i),
    .selection_line (nh_sel),
    .grant          (nh_grant),
    .grant_valid    (nh_valid),
    .timeout        (nh_timeout)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rel;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  // Downstream mux data: i0..i3 = 1,0,1,0
  logic [3:0] mux_in = 4'b0101;
  logic       mux_y;
  assign mux_y = mux_in[selection_line];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic l,
                              input logic [3:0] g, input logic [1:0] s,
                              input logic v, input logic t);
    vec_t x;
    x.rst_n = r; x.req = q; x.rel = l;
    x.grant = g; x.sel = s; x.valid = v; x.to = t;
    return x;
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic pop_compare(input string name);
    vec_t e;
    logic inv_ok;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty got 1 expected 0", name);
    end else begin
      e = sb.pop_front();
      // Output order in the compared byte: {grant, sel, valid, timeout}
      check(name, {grant, selection_line, grant_valid, timeout},
            {e.grant, e.sel, e.valid, e.to});
    end
    inv_ok = ((grant & (grant - 4'd1)) == 4'd0) &&
             ((grant != 4'd0) == grant_valid) &&
             (!grant_valid || (grant == (4'b0001 << selection_line)));
    check({name, "_inv"}, {7'd0, inv_ok}, 8'd1);
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst_n     = v.rst_n;
    req       = v.req;
    release_i = v.rel;
    sb.push_back(v);
    @(posedge clk);
    #1;
    pop_compare(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_y [5];
    rst_n = 1'b0; req = '0; release_i = 1'b0;

    // Reset with all channels requesting, then a single requester
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 4'b0100, 2'b10, 1, 0));
    // Round-robin with release_i held high
    tbl.push_back(mk(0, 4'b0000, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0010, 2'b01, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0100, 2'b10, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b1000, 2'b11, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0001, 2'b00, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 1, 4'b0010, 2'b01, 1, 0));
    // Request drop while channel 2 owns the grant
    tbl.push_back(mk(1, 4'b1101, 1, 4'b0100, 2'b10, 1, 0));
    tbl.push_back(mk(1, 4'b1101, 0, 4'b0100, 2'b10, 1, 0));
    tbl.push_back(mk(1, 4'b1001, 0, 4'b1000, 2'b11, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 4'b0000, 2'b11, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 1, 4'b0000, 2'b11, 0, 0));
    // Channel 1 holds for five cycles, then a reset arrives mid-grant
    tbl.push_back(mk(1, 4'b0010, 0, 4'b0010, 2'b01, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 4'b0010, 0, 4'b0010, 2'b01, 1, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(1, 4'b1010, 0, 4'b0010, 2'b01, 1, 0));
    // With ptr=2 before reset, the pointer must return to 0 after reset
    tbl.push_back(mk(1, 4'b1010, 1, 4'b1000, 2'b11, 1, 0));
    tbl.push_back(mk(0, 4'b1001, 0, 4'b0000, 2'b00, 0, 0));
    tbl.push_back(mk(1, 4'b1001, 0, 4'b0001, 2'b00, 1, 0));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("tbl%0d", i));

    // Channel 0 is the only requester: timeout every 16 cycles, grant never drops
    apply(mk(0, 4'b0001, 0, 4'b0000, 2'b00, 0, 0), "to1_rst");
    for (int k = 0; k <= 32; k++) begin
      apply(mk(1, 4'b0001, 0, 4'b0001, 2'b00, 1, (k == 16 || k == 32)),
            $sformatf("to1_k%0d", k));
      check($sformatf("nohold_k%0d", k), {nh_grant, nh_sel, nh_valid, nh_timeout},
            {4'b0001, 2'b00, 1'b1, 1'b0});
    end

    // Two requesters: the timeout hands the grant to the other channel
    apply(mk(0, 4'b0011, 0, 4'b0000, 2'b00, 0, 0), "to2_rst");
    for (int k = 0; k <= 32; k++) begin
      if (k < 16)
        apply(mk(1, 4'b0011, 0, 4'b0001, 2'b00, 1, 0), $sformatf("to2_k%0d", k));
      else if (k < 32)
        apply(mk(1, 4'b0011, 0, 4'b0010, 2'b01, 1, (k == 16)), $sformatf("to2_k%0d", k));
      else
        apply(mk(1, 4'b0011, 0, 4'b0001, 2'b00, 1, 1), $sformatf("to2_k%0d", k));
    end

    // release_i on the hold-limit edge is a normal release with no timeout
    apply(mk(0, 4'b0001, 0, 4'b0000, 2'b00, 0, 0), "to3_rst");
    for (int k = 0; k <= 32; k++)
      apply(mk(1, 4'b0001, (k == 16), 4'b0001, 2'b00, 1, (k == 32)),
            $sformatf("to3_k%0d", k));

    // Mux integration: mux output follows the grant order 1,0,1,0,1
    exp_y[0] = 1'b1; exp_y[1] = 1'b0; exp_y[2] = 1'b1; exp_y[3] = 1'b0; exp_y[4] = 1'b1;
    apply(mk(0, 4'b0000, 0, 4'b0000, 2'b00, 0, 0), "mux_rst");
    for (int k = 0; k < 5; k++) begin
      apply(mk(1, 4'b1111, 1, 4'b0001 << (k % 4), 2'(k % 4), 1, 0),
            $sformatf("mux_g%0d", k));
      check($sformatf("mux_y%0d", k), {6'd0, grant_valid, mux_y}, {6'd0, 1'b1, exp_y[k]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
